median_frame_scheduler: RTL and testbench
=========================================

MEDIAN_FRAME_SCHEDULER -- requirements
Module: median_frame_scheduler

Interface
REQ-001 Parameter IMAGE_WIDTH, default 8, sets pixels per row.
REQ-002 Parameter IMAGE_HEIGHT, default 8, sets rows per frame.
REQ-003 Parameter PIXEL_WIDTH, default 8, sets pixel bit width.
REQ-004 Parameter FLUSH_CYCLES, default 22, sets post-frame cycles of held valid that drain the filter line buffers.
REQ-005 Parameter TIMEOUT_CYCLES, default 150, sets the maximum wait in WAIT_DONE for frame completion.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-007 Ports, one per line:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle frame start request
- abort  in  1  one-cycle abort request
- src_valid  in  1  source pixel valid
- src_data  in  PIXEL_WIDTH  source pixel
- src_ready  out  1  scheduler accepts pixel
- filt_valid  out  1  drives filter data_valid
- filt_data  out  PIXEL_WIDTH  drives filter data_in
- filt_valid_out  in  1  filter output strobe
- filt_frame_complete  in  1  filter frame_complete
- busy  out  1  state not IDLE
- done  out  1  one-cycle frame-finished pulse
- timeout_err  out  1  sticky timeout flag
- count_err  out  1  sticky output-count mismatch flag
- out_count  out  clog2(W*H+1)  filter outputs seen in current frame

Function
REQ-008 States SHALL be IDLE, FEED, FLUSH, WAIT_DONE, DONE, ERROR.
REQ-009 IDLE -> FEED on start; in the same transition the scheduler SHALL clear the pixel counter, out_count, timeout_err and count_err.
REQ-010 src_ready SHALL be 1 only in FEED; a pixel is accepted when src_valid and src_ready are both 1.
REQ-011 On each accepted pixel, filt_valid SHALL be 1 and filt_data SHALL equal src_data on the next cycle (1-cycle latency).
REQ-012 In FEED, filt_valid SHALL be 0 on the cycle after a non-accepting cycle.
REQ-013 FEED -> FLUSH when the accepted-pixel count reaches IMAGE_WIDTH*IMAGE_HEIGHT.
REQ-014 FLUSH SHALL drive filt_valid=1 with filt_data holding the last pixel for exactly FLUSH_CYCLES cycles, then go to WAIT_DONE.
REQ-015 WAIT_DONE SHALL drive filt_valid=0 and count cycles.
REQ-016 WAIT_DONE -> DONE on filt_frame_complete.
REQ-017 WAIT_DONE -> ERROR with timeout_err=1 when the cycle count reaches TIMEOUT_CYCLES and filt_frame_complete=0.
REQ-018 When filt_frame_complete and timeout expiry coincide, DONE SHALL win.
REQ-019 out_count SHALL increment on every filt_valid_out outside IDLE, and SHALL saturate at IMAGE_WIDTH*IMAGE_HEIGHT.
REQ-020 DONE SHALL assert done for one cycle, set count_err if out_count != IMAGE_WIDTH*IMAGE_HEIGHT, then return to IDLE.
REQ-021 ERROR SHALL hold until start, which clears the flags and enters FEED.
REQ-022 start outside IDLE/ERROR SHALL be ignored.
REQ-023 filt_frame_complete in FEED or FLUSH SHALL be ignored.
REQ-024 abort in any non-IDLE state SHALL force IDLE next cycle with filt_valid=0, done=0 and flags unchanged.
REQ-025 When abort and start coincide, abort SHALL win.
REQ-026 busy SHALL equal (state != IDLE).

Reset
REQ-027 rst SHALL asynchronously force state IDLE and all outputs to 0, including filt_data, out_count and both flags; counters SHALL clear.
REQ-028 rst asserted mid-frame SHALL drop filt_valid immediately, and no done pulse SHALL follow.

Structure
REQ-029 State encoding and default parameter constants SHALL live in the shared package median_pkg.
REQ-030 The design SHALL have one sub-module, median_cycle_counter: a loadable down-counter with zero flag, reused for FLUSH and timeout.

Verification
REQ-031 Nominal 8x8 frame with continuous src_valid: 64 filt_valid, then 22 flush cycles; complete at WAIT_DONE cycle 5 -> done single pulse, busy falls, count_err=0 with 64 outputs.
REQ-032 src_valid low every other cycle: all 64 pixels forwarded in order with 1-cycle latency; filt_valid gaps match source gaps.
REQ-033 No filt_frame_complete: timeout_err=1 exactly 150 cycles after WAIT_DONE entry; state ERROR; start clears it.
REQ-034 Complete arriving on cycle 150 of WAIT_DONE -> done=1, timeout_err=0; only 63 filt_valid_out pulses -> count_err=1.
REQ-035 abort at pixel 30, then start at the same cycle as a second abort: IDLE, no done; next start restarts the count from 0.
REQ-036 rst asserted during FLUSH: all outputs 0 asynchronously; frame restarts cleanly on the next start.

Source files
------------

// File: rtl/median_pkg.sv
// Shared state encoding and default constants for the median frame scheduler.
package median_pkg;

    localparam int DEF_IMAGE_WIDTH    = 8;
    localparam int DEF_IMAGE_HEIGHT   = 8;
    localparam int DEF_PIXEL_WIDTH    = 8;
    localparam int DEF_FLUSH_CYCLES   = 22;
    localparam int DEF_TIMEOUT_CYCLES = 150;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FEED      = 3'd1,
        ST_FLUSH     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DONE      = 3'd4,
        ST_ERROR     = 3'd5
    } state_t;

    // Larger of two integers, used to size the shared flush/timeout counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/median_cycle_counter.sv
// Loadable down-counter with a zero flag; shared between the flush and timeout phases.
module median_cycle_counter
    import median_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_enable,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // A load takes priority over counting; the count rests at zero rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/median_frame_scheduler.sv
// Frame scheduler that feeds one image into a median filter, flushes its line
// buffers, then waits for the filter to report frame completion.
module median_frame_scheduler
    import median_pkg::*;
#(
    parameter int IMAGE_WIDTH    = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT   = DEF_IMAGE_HEIGHT,
    parameter int PIXEL_WIDTH    = DEF_PIXEL_WIDTH,
    parameter int FLUSH_CYCLES   = DEF_FLUSH_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic                                          abort,
    input  logic                                          src_valid,
    input  logic [PIXEL_WIDTH-1:0]                        src_data,
    output logic                                          src_ready,
    output logic                                          filt_valid,
    output logic [PIXEL_WIDTH-1:0]                        filt_data,
    input  logic                                          filt_valid_out,
    input  logic                                          filt_frame_complete,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          timeout_err,
    output logic                                          count_err,
    output logic [$clog2(IMAGE_WIDTH*IMAGE_HEIGHT+1)-1:0] out_count
);

    localparam int NUM_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int CNT_W      = $clog2(NUM_PIXELS + 1);
    localparam int TMR_W      = $clog2(max_int(FLUSH_CYCLES, TIMEOUT_CYCLES) + 1);

    localparam logic [CNT_W-1:0] FRAME_PIXELS = CNT_W'(NUM_PIXELS);
    localparam logic [TMR_W-1:0] FLUSH_LOAD   = TMR_W'(FLUSH_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_W-1:0]       r_pix_cnt;
    logic [CNT_W-1:0]       r_out_count;
    logic                   r_filt_valid;
    logic [PIXEL_WIDTH-1:0] r_filt_data;
    logic                   r_timeout_err;
    logic                   r_count_err;

    logic                   w_frame_fed;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_start_clear;
    logic                   w_set_timeout;
    logic                   w_tmr_load;
    logic [TMR_W-1:0]       w_tmr_value;
    logic                   w_tmr_enable;
    logic                   w_tmr_zero;
    logic                   w_next_valid;

    assign w_frame_fed  = (r_pix_cnt == FRAME_PIXELS);
    assign w_ready      = (r_state == ST_FEED) && !w_frame_fed;
    assign w_accept     = src_valid && w_ready;
    assign w_tmr_enable = (r_state == ST_FLUSH) || (r_state == ST_WAIT_DONE);

    // Next-state decode; abort always wins and also decides which phase the shared timer is loaded for.
    always_comb begin
        w_next_state  = r_state;
        w_start_clear = 1'b0;
        w_set_timeout = 1'b0;
        w_tmr_load    = 1'b0;
        w_tmr_value   = FLUSH_LOAD;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_next_state  = ST_FEED;
                    w_start_clear = 1'b1;
                end
            end
            ST_FEED: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_frame_fed) begin
                    w_next_state = ST_FLUSH;
                    w_tmr_load   = 1'b1;
                    w_tmr_value  = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_tmr_zero) begin
                    w_next_state = ST_WAIT_DONE;
                    w_tmr_load   = 1'b1;
                    w_tmr_value  = TIMEOUT_LOAD;
                end
            end
            ST_WAIT_DONE: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (filt_frame_complete) begin
                    w_next_state = ST_DONE;
                end else if (w_tmr_zero) begin
                    w_next_state  = ST_ERROR;
                    w_set_timeout = 1'b1;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            ST_ERROR: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (start) begin
                    w_next_state  = ST_FEED;
                    w_start_clear = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // filt_valid is registered so it lines up with the state it belongs to: the echo of an accepted pixel, or held high through FLUSH.
    assign w_next_valid = (w_accept && !abort) || (w_next_state == ST_FLUSH);

    median_cycle_counter #(
        .WIDTH (TMR_W)
    ) u_cycle_counter (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_tmr_load),
        .i_load_value (w_tmr_value),
        .i_enable     (w_tmr_enable),
        .o_zero       (w_tmr_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Forwarding path to the filter; the last accepted pixel stays on filt_data during the flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt_valid <= 1'b0;
            r_filt_data  <= '0;
        end else begin
            r_filt_valid <= w_next_valid;
            if (w_accept) begin
                r_filt_data <= src_data;
            end
        end
    end

    // Accepted-pixel and filter-output counters, both restarted when a frame is launched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix_cnt   <= '0;
            r_out_count <= '0;
        end else if (w_start_clear) begin
            r_pix_cnt   <= '0;
            r_out_count <= '0;
        end else begin
            if (w_accept) begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
            end
            if ((r_state != ST_IDLE) && filt_valid_out && (r_out_count != FRAME_PIXELS)) begin
                r_out_count <= r_out_count + 1'b1;
            end
        end
    end

    // Sticky error flags; only a new frame launch clears them, abort leaves them alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timeout_err <= 1'b0;
            r_count_err   <= 1'b0;
        end else if (w_start_clear) begin
            r_timeout_err <= 1'b0;
            r_count_err   <= 1'b0;
        end else begin
            if (w_set_timeout) begin
                r_timeout_err <= 1'b1;
            end
            if ((r_state == ST_DONE) && !abort && (r_out_count != FRAME_PIXELS)) begin
                r_count_err <= 1'b1;
            end
        end
    end

    assign src_ready   = w_ready;
    assign filt_valid  = r_filt_valid;
    assign filt_data   = r_filt_data;
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign timeout_err = r_timeout_err;
    assign count_err   = r_count_err;
    assign out_count   = r_out_count;

endmodule

// File: tb/tb_median_frame_scheduler.sv
// Directed bench for median_frame_scheduler: nominal frame, gapped source,
// timeout, late completion, abort handling and asynchronous reset mid-flush.
module tb_median_frame_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       src_valid;
    logic [7:0] src_data;
    logic       src_ready;
    logic       filt_valid;
    logic [7:0] filt_data;
    logic       filt_valid_out;
    logic       filt_frame_complete;
    logic       busy;
    logic       done;
    logic       timeout_err;
    logic       count_err;
    logic [6:0] out_count;

    int total = 0;
    int bad   = 0;

    median_frame_scheduler #(
        .IMAGE_WIDTH    (8),
        .IMAGE_HEIGHT   (8),
        .PIXEL_WIDTH    (8),
        .FLUSH_CYCLES   (22),
        .TIMEOUT_CYCLES (150)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .abort               (abort),
        .src_valid           (src_valid),
        .src_data            (src_data),
        .src_ready           (src_ready),
        .filt_valid          (filt_valid),
        .filt_data           (filt_data),
        .filt_valid_out      (filt_valid_out),
        .filt_frame_complete (filt_frame_complete),
        .busy                (busy),
        .done                (done),
        .timeout_err         (timeout_err),
        .count_err           (count_err),
        .out_count           (out_count)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge, let the rising edge take them, and return at the next falling edge.
    task automatic applyStimulus(input logic iStart, input logic iAbort, input logic iValid,
                                 input logic [7:0] iData, input logic iFvo, input logic iComplete);
        start               = iStart;
        abort               = iAbort;
        src_valid           = iValid;
        src_data            = iData;
        filt_valid_out      = iFvo;
        filt_frame_complete = iComplete;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Idle cycles with every input low.
    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        end
    endtask

    // One counted comparison.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Directed scenario sequence.
    initial begin
        int validSeen;
        int dataErrs;
        int gapErrs;
        int flushSeen;
        int doneSeen;
        logic v;

        rst                 = 1'b1;
        start               = 1'b0;
        abort               = 1'b0;
        src_valid           = 1'b0;
        src_data            = 8'd0;
        filt_valid_out      = 1'b0;
        filt_frame_complete = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state.
        checkOutput("rst_busy",        32'(busy), 0);
        checkOutput("rst_done",        32'(done), 0);
        checkOutput("rst_filt_valid",  32'(filt_valid), 0);
        checkOutput("rst_filt_data",   32'(filt_data), 0);
        checkOutput("rst_out_count",   32'(out_count), 0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 0);
        checkOutput("rst_count_err",   32'(count_err), 0);
        checkOutput("rst_src_ready",   32'(src_ready), 0);
        rst = 1'b0;
        idleCycles(1);

        // Nominal frame with continuous source.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        checkOutput("nom_busy",        32'(busy), 1);
        checkOutput("nom_src_ready",   32'(src_ready), 1);
        checkOutput("nom_out_cleared", 32'(out_count), 0);
        validSeen = 0;
        dataErrs  = 0;
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'(i + 1), 1'b1, 1'b0);
            if (filt_valid === 1'b1) validSeen++;
            if (filt_data !== 8'(i + 1)) dataErrs++;
        end
        checkOutput("nom_pixel_valid", validSeen, 64);
        checkOutput("nom_pixel_data",  dataErrs, 0);
        checkOutput("nom_ready_drop",  32'(src_ready), 0);
        flushSeen = 0;
        for (int k = 0; k < 22; k++) begin
            idleCycles(1);
            if ((filt_valid === 1'b1) && (filt_data === 8'd64)) flushSeen++;
        end
        checkOutput("nom_flush_cycles", flushSeen, 22);
        idleCycles(1);
        checkOutput("nom_wait_valid_low", 32'(filt_valid), 0);
        checkOutput("nom_wait_busy",      32'(busy), 1);
        idleCycles(4);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
        checkOutput("nom_done_pulse", 32'(done), 1);
        idleCycles(1);
        checkOutput("nom_done_single", 32'(done), 0);
        checkOutput("nom_busy_fall",   32'(busy), 0);
        checkOutput("nom_count_err",   32'(count_err), 0);
        checkOutput("nom_out_count",   32'(out_count), 64);
        checkOutput("nom_timeout_err", 32'(timeout_err), 0);

        // Source valid every other cycle, a stray complete in FEED, then no completion at all.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        validSeen = 0;
        dataErrs  = 0;
        gapErrs   = 0;
        for (int i = 0; i < 127; i++) begin
            v = ((i % 2) == 0);
            applyStimulus(1'b0, 1'b0, v, 8'(100 + i / 2), 1'b0, (i == 5));
            if (filt_valid !== v) gapErrs++;
            if (v && (filt_data !== 8'(100 + i / 2))) dataErrs++;
            if (filt_valid === 1'b1) validSeen++;
        end
        checkOutput("gap_pattern", gapErrs, 0);
        checkOutput("gap_data",    dataErrs, 0);
        checkOutput("gap_count",   validSeen, 64);
        idleCycles(23);
        checkOutput("to_wait_entry", 32'(filt_valid), 0);
        idleCycles(149);
        checkOutput("to_not_yet", 32'(timeout_err), 0);
        checkOutput("to_busy",    32'(busy), 1);
        idleCycles(1);
        checkOutput("to_flag",      32'(timeout_err), 1);
        checkOutput("to_err_busy",  32'(busy), 1);
        checkOutput("to_err_ready", 32'(src_ready), 0);
        checkOutput("to_err_done",  32'(done), 0);

        // Start out of ERROR clears the flag; a start mid-frame is ignored; completion lands on the last wait cycle.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        checkOutput("err_restart_flag",  32'(timeout_err), 0);
        checkOutput("err_restart_ready", 32'(src_ready), 1);
        checkOutput("err_restart_count", 32'(out_count), 0);
        for (int i = 0; i < 64; i++) begin
            applyStimulus((i == 10), 1'b0, 1'b1, 8'(200 - i), (i < 63), 1'b0);
        end
        checkOutput("late_ready_drop", 32'(src_ready), 0);
        checkOutput("late_out_count",  32'(out_count), 63);
        idleCycles(23);
        idleCycles(149);
        checkOutput("late_no_timeout", 32'(timeout_err), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
        checkOutput("late_done",        32'(done), 1);
        checkOutput("late_timeout_low", 32'(timeout_err), 0);
        idleCycles(1);
        checkOutput("late_count_err", 32'(count_err), 1);
        checkOutput("late_idle",      32'(busy), 0);

        // Abort at pixel 30, then start coinciding with a second abort, then a clean restart.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd30, 1'b0, 1'b0);
        checkOutput("abort_busy",    32'(busy), 0);
        checkOutput("abort_valid",   32'(filt_valid), 0);
        checkOutput("abort_done",    32'(done), 0);
        checkOutput("abort_flags",   32'(count_err), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        checkOutput("abort_start_busy", 32'(busy), 0);
        checkOutput("abort_start_done", 32'(done), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        checkOutput("restart_busy",  32'(busy), 1);
        checkOutput("restart_count", 32'(out_count), 0);
        for (int i = 0; i < 63; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'(i + 7), 1'b1, 1'b0);
        end
        checkOutput("restart_ready_63", 32'(src_ready), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd77, 1'b1, 1'b0);
        checkOutput("restart_ready_64", 32'(src_ready), 0);

        // Asynchronous reset in the middle of FLUSH.
        idleCycles(5);
        checkOutput("flush_before_rst", 32'(filt_valid), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_valid",     32'(filt_valid), 0);
        checkOutput("arst_data",      32'(filt_data), 0);
        checkOutput("arst_busy",      32'(busy), 0);
        checkOutput("arst_out_count", 32'(out_count), 0);
        checkOutput("arst_ready",     32'(src_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        doneSeen = 0;
        for (int k = 0; k < 10; k++) begin
            idleCycles(1);
            if (done !== 1'b0) doneSeen++;
        end
        checkOutput("arst_no_done", doneSeen, 0);
        checkOutput("arst_idle",    32'(busy), 0);

        // Clean frame after the reset.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'(i + 50), 1'b1, 1'b0);
        end
        checkOutput("post_rst_last_data", 32'(filt_data), 113);
        idleCycles(23);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
        checkOutput("post_rst_done", 32'(done), 1);
        idleCycles(1);
        checkOutput("post_rst_count_err", 32'(count_err), 0);
        checkOutput("post_rst_out_count", 32'(out_count), 64);
        checkOutput("post_rst_idle",      32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
